pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Pipeline control unit for the 5-stage CPU: generates per-stage stall/flush, owns the control-register file (status, EPC, cause, vector, interrupt mask), and sequences exception entry and EXRT return. It consumes the ID-stage load-hazard flag, the MEM-stage exception/ctrl results and bus busy flags, and drives new_pc back to the IF stage. It is the sole source of exe_mode and creg_rd_data for the decoder.

## Interface
Parameters:
- IRQ_W, 8, external interrupt request lines
- CREG_N, 8, number of control registers (addresses 0..CREG_N-1)

Ports:
- clk  in  1  system clock
- reset_  in  1  **one clock; reset is synchronous and active-low**
- if_busy  in  1  IF bus access pending
- ld_hazard  in  1  load-use hazard from decoder
- mem_busy  in  1  MEM bus access pending
- id_pc  in  30  word PC of instruction in ID
- mem_pc  in  30  word PC of instruction leaving MEM
- mem_en  in  1  MEM stage holds a valid instruction
- mem_br_flag  in  1  MEM instruction is a branch (next is delay slot)
- mem_ctrl_op  in  2  NOP=0, WRCR=1, EXRT=2
- mem_dst_addr  in  5  control-register address for WRCR
- mem_exp_code  in  3  exception code from pipeline
- mem_out  in  32  WRCR write data
- irq  in  IRQ_W  level-sensitive interrupt requests
- creg_rd_addr  in  5  combinational read address (from decoder)
- creg_rd_data  out  32  combinational read data
- exe_mode  out  1  KERNEL=0, USER=1
- int_detect  out  1  unmasked enabled interrupt pending
- if_stall, id_stall, ex_stall, mem_stall  out  1 each
- if_flush, id_flush, ex_flush, mem_flush  out  1 each
- new_pc  out  30  redirect target, valid when flush=1

## Operation
- Control registers: 0 STATUS{int_en[1],exe_mode[0]}; 1 PRE_STATUS; 2 EPC[31:2]; 3 EXP_VECTOR[31:2]; 4 CAUSE{dly_flag[3],exp_code[2:0]}; 5 INT_MASK[IRQ_W-1:0] (1=masked); 6 IRQ (read-only, live irq); 7 reserved (reads 0). Unused bits read 0; reads of addr ≥ CREG_N return 0.
- Exception codes: NO_EXP=0, EXT_INT=1, UNDEF_INSN=2, OVERFLOW=3, MISS_ALIGN=4, TRAP=5, PRV_VIO=6.
- int_detect = STATUS.int_en & |(irq & ~INT_MASK).
- stall = if_busy | mem_busy. All four stall outputs = stall; additionally if_stall |= ld_hazard.
- Event (evaluated only when mem_en=1 and stall=0), priority: (1) exception: mem_exp_code≠NO_EXP, or int_detect (code EXT_INT, int outranks pipeline code); (2) EXRT; (3) WRCR.
- Exception: all flushes=1, new_pc=EXP_VECTOR; on edge: PRE_STATUS←STATUS, STATUS←{0,KERNEL}, CAUSE←{mem_br_flag, code}, EPC←mem_br_flag ? mem_pc : mem_pc+1 for TRAP, else mem_pc (branch-delay exceptions and non-TRAP codes restart the faulting instruction; delay-slot case reported via dly_flag, EPC already points to the branch because MEM carries the branch PC when br_flag set).
- EXRT: all flushes=1, new_pc=EPC; on edge STATUS←PRE_STATUS.
- WRCR: no flush; on edge register[mem_dst_addr]←mem_out (writes to 6/7 ignored).
- Otherwise: flushes=0 except id_flush=ld_hazard (bubble insert); new_pc=0.
- FSM: RUN, FLUSH. Exception/EXRT in RUN → FLUSH for exactly one cycle, during which int_detect-driven exceptions are suppressed (prevents re-entry before new PC fetch); FLUSH → RUN unconditionally.

## Timing
- creg_rd_data, stalls, flushes, new_pc: combinational, same cycle. Register updates: next rising edge.
- WRCR then RDCR back-to-back: creg_rd_data bypasses pending WRCR data when mem_ctrl_op=WRCR and addresses match.
- Reset (reset_=0 at edge): STATUS={0,KERNEL}, PRE_STATUS=0, EPC=0, EXP_VECTOR=0, CAUSE=0, INT_MASK=all 1, FSM=RUN. Outputs during/after reset derive from these: exe_mode=0, int_detect=0.
- Reset asserted mid-FLUSH returns to RUN; no register write that cycle.
- Stall and exception same cycle: exception deferred, no flush, no register update until stall clears.
- EPC+1 wraps modulo 2^30.

## Structure
- Shared package/header (cpu.vh/isa.vh): CREG address constants, exception codes, CTRL_OP codes, CPU_KERNEL_MODE/USER_MODE, FSM state encodings.
- One sub-module natural: creg_file (register storage, write port, bypassed read mux); pipeline_ctrl holds stall/flush logic, event priority and FSM.

## Test plan
- Reset, then creg_rd_addr=0 → creg_rd_data=0, exe_mode=0, INT_MASK read 0xFF.
- WRCR addr3=0x0000_0100 then exception code UNDEF_INSN at mem_pc=0x40 → all flushes=1, new_pc=0x40, next cycle EPC=0x40, CAUSE=2, STATUS=0.
- TRAP at mem_pc=0x20, then EXRT → new_pc=0x21, STATUS restored to PRE_STATUS value.
- STATUS.int_en=1, INT_MASK=0xFE, irq=0x01 → int_detect=1, exception EXT_INT; irq=0x02 → int_detect=0.
- ld_hazard=1, no other event → if_stall=1, id_flush=1, other flushes 0.
- mem_busy=1 with OVERFLOW pending → no flush, registers unchanged; mem_busy drops → exception taken that cycle.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline control unit: control-register map,
// exception and control-op codes, execution modes and FSM states.
package pipeline_ctrl_pkg;
  localparam logic [4:0] CREG_STATUS     = 5'd0;
  localparam logic [4:0] CREG_PRE_STATUS = 5'd1;
  localparam logic [4:0] CREG_EPC        = 5'd2;
  localparam logic [4:0] CREG_EXP_VECTOR = 5'd3;
  localparam logic [4:0] CREG_CAUSE      = 5'd4;
  localparam logic [4:0] CREG_INT_MASK   = 5'd5;
  localparam logic [4:0] CREG_IRQ        = 5'd6;

  localparam logic CPU_KERNEL_MODE = 1'b0;
  localparam logic CPU_USER_MODE   = 1'b1;

  typedef enum logic [2:0] {
    NO_EXP = 3'd0, EXT_INT = 3'd1, UNDEF_INSN = 3'd2, OVERFLOW = 3'd3,
    MISS_ALIGN = 3'd4, TRAP = 3'd5, PRV_VIO = 3'd6
  } exp_code_e;

  typedef enum logic [1:0] {
    CTRL_NOP = 2'd0, CTRL_WRCR = 2'd1, CTRL_EXRT = 2'd2
  } ctrl_op_e;

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_e;

  typedef struct packed {
    logic int_en;
    logic exe_mode;
  } status_t;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle of pipeline-side signals seen by the control unit; slave is the
// controller view, master is the pipeline/driver view.
interface pipeline_ctrl_if #(parameter int IRQ_W = 8);
  logic             if_busy, ld_hazard, mem_busy;
  logic [29:0]      id_pc, mem_pc;
  logic             mem_en, mem_br_flag;
  logic [1:0]       mem_ctrl_op;
  logic [4:0]       mem_dst_addr;
  logic [2:0]       mem_exp_code;
  logic [31:0]      mem_out;
  logic [IRQ_W-1:0] irq;
  logic [4:0]       creg_rd_addr;
  logic [31:0]      creg_rd_data;
  logic             exe_mode, int_detect;
  logic             if_stall, id_stall, ex_stall, mem_stall;
  logic             if_flush, id_flush, ex_flush, mem_flush;
  logic [29:0]      new_pc;

  modport slave (
    input  if_busy, ld_hazard, mem_busy, id_pc, mem_pc, mem_en, mem_br_flag,
           mem_ctrl_op, mem_dst_addr, mem_exp_code, mem_out, irq, creg_rd_addr,
    output creg_rd_data, exe_mode, int_detect,
           if_stall, id_stall, ex_stall, mem_stall,
           if_flush, id_flush, ex_flush, mem_flush, new_pc
  );
  modport master (
    output if_busy, ld_hazard, mem_busy, id_pc, mem_pc, mem_en, mem_br_flag,
           mem_ctrl_op, mem_dst_addr, mem_exp_code, mem_out, irq, creg_rd_addr,
    input  creg_rd_data, exe_mode, int_detect,
           if_stall, id_stall, ex_stall, mem_stall,
           if_flush, id_flush, ex_flush, mem_flush, new_pc
  );
endinterface

// File: rtl/pipeline_ctrl_creg_file.sv
// Control-register storage: exception entry / EXRT / WRCR write ports and a
// combinational read mux that forwards a WRCR still sitting in MEM.
module pipeline_ctrl_creg_file
  import pipeline_ctrl_pkg::*;
#(
  parameter int IRQ_W  = 8,
  parameter int CREG_N = 8
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             exc_en,
  input  logic [3:0]       exc_cause,
  input  logic [29:0]      exc_epc,
  input  logic             exrt_en,
  input  logic             wr_en,
  input  logic             byp_en,
  input  logic [4:0]       wr_addr,
  input  logic [31:0]      wr_data,
  input  logic [IRQ_W-1:0] irq,
  input  logic [4:0]       rd_addr,
  output logic [31:0]      rd_data,
  output status_t          status,
  output logic [29:0]      epc,
  output logic [29:0]      exp_vector,
  output logic [IRQ_W-1:0] int_mask
);
  status_t          status_q, status_d, pre_status_q, pre_status_d;
  logic [29:0]      epc_q, epc_d, vec_q, vec_d;
  logic [3:0]       cause_q, cause_d;
  logic [IRQ_W-1:0] mask_q, mask_d;
  logic             wr_ok;
  logic [31:0]      wr_view;

  assign status     = status_q;
  assign epc        = epc_q;
  assign exp_vector = vec_q;
  assign int_mask   = mask_q;

  // Only STATUS..INT_MASK are writable; IRQ and reserved slots ignore WRCR.
  assign wr_ok = (wr_addr <= CREG_INT_MASK) && (32'(wr_addr) < CREG_N);

  always_comb begin
    wr_view = '0;
    case (wr_addr)
      CREG_STATUS, CREG_PRE_STATUS: wr_view = {30'd0, wr_data[1:0]};
      CREG_EPC, CREG_EXP_VECTOR:    wr_view = {wr_data[31:2], 2'b00};
      CREG_CAUSE:                   wr_view = {28'd0, wr_data[3:0]};
      CREG_INT_MASK:                wr_view = 32'(wr_data[IRQ_W-1:0]);
      default:                      wr_view = '0;
    endcase
  end

  always_comb begin
    rd_data = '0;
    if (32'(rd_addr) < CREG_N) begin
      case (rd_addr)
        CREG_STATUS:     rd_data = {30'd0, status_q};
        CREG_PRE_STATUS: rd_data = {30'd0, pre_status_q};
        CREG_EPC:        rd_data = {epc_q, 2'b00};
        CREG_EXP_VECTOR: rd_data = {vec_q, 2'b00};
        CREG_CAUSE:      rd_data = {28'd0, cause_q};
        CREG_INT_MASK:   rd_data = 32'(mask_q);
        CREG_IRQ:        rd_data = 32'(irq);
        default:         rd_data = '0;
      endcase
    end
    if (byp_en && wr_ok && (rd_addr == wr_addr)) rd_data = wr_view;
  end

  always_comb begin
    status_d     = status_q;
    pre_status_d = pre_status_q;
    epc_d        = epc_q;
    vec_d        = vec_q;
    cause_d      = cause_q;
    mask_d       = mask_q;
    if (exc_en) begin
      pre_status_d = status_q;
      status_d     = '{int_en: 1'b0, exe_mode: CPU_KERNEL_MODE};
      cause_d      = exc_cause;
      epc_d        = exc_epc;
    end else if (exrt_en) begin
      status_d = pre_status_q;
    end else if (wr_en && wr_ok) begin
      case (wr_addr)
        CREG_STATUS:     status_d     = wr_data[1:0];
        CREG_PRE_STATUS: pre_status_d = wr_data[1:0];
        CREG_EPC:        epc_d        = wr_data[31:2];
        CREG_EXP_VECTOR: vec_d        = wr_data[31:2];
        CREG_CAUSE:      cause_d      = wr_data[3:0];
        CREG_INT_MASK:   mask_d       = wr_data[IRQ_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      status_q     <= '{int_en: 1'b0, exe_mode: CPU_KERNEL_MODE};
      pre_status_q <= '0;
      epc_q        <= '0;
      vec_q        <= '0;
      cause_q      <= '0;
      mask_q       <= '1;
    end else begin
      status_q     <= status_d;
      pre_status_q <= pre_status_d;
      epc_q        <= epc_d;
      vec_q        <= vec_d;
      cause_q      <= cause_d;
      mask_q       <= mask_d;
    end
  end
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control: stall/flush generation, MEM-stage event priority
// (exception > EXRT > WRCR), redirect PC and the RUN/FLUSH sequencer.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int IRQ_W  = 8,
  parameter int CREG_N = 8
) (
  input logic             clk,
  input logic             reset_,
  pipeline_ctrl_if.slave  bus
);
  state_e      state_q, state_d;
  status_t     status;
  logic [29:0] epc, exp_vector, exc_epc;
  logic [IRQ_W-1:0] int_mask;
  logic        stall, act, int_detect, int_take, exc_en, exrt_en, wr_en, flush_all;
  logic [2:0]  exc_code;
  logic        unused_id_pc;

  assign unused_id_pc = ^bus.id_pc;

  assign stall      = bus.if_busy | bus.mem_busy;
  assign act        = bus.mem_en & ~stall;
  assign int_detect = status.int_en & (|(bus.irq & ~int_mask));
  // Interrupts stay off for the one cycle after a redirect so the handler's
  // first fetch lands before another entry can fire.
  assign int_take   = int_detect & (state_q == ST_RUN);
  assign exc_en     = act & (int_take | (bus.mem_exp_code != NO_EXP));
  assign exc_code   = int_take ? EXT_INT : bus.mem_exp_code;
  assign exrt_en    = act & ~exc_en & (bus.mem_ctrl_op == CTRL_EXRT);
  assign wr_en      = act & ~exc_en & ~exrt_en & (bus.mem_ctrl_op == CTRL_WRCR);
  assign flush_all  = exc_en | exrt_en;
  // A TRAP outside a delay slot resumes after the trap; everything else replays.
  assign exc_epc    = ((exc_code == TRAP) && !bus.mem_br_flag) ? bus.mem_pc + 30'd1 : bus.mem_pc;

  assign bus.int_detect = int_detect;
  assign bus.exe_mode   = status.exe_mode;
  assign bus.if_stall   = stall | bus.ld_hazard;
  assign bus.id_stall   = stall;
  assign bus.ex_stall   = stall;
  assign bus.mem_stall  = stall;
  assign bus.if_flush   = flush_all;
  assign bus.id_flush   = flush_all | bus.ld_hazard;
  assign bus.ex_flush   = flush_all;
  assign bus.mem_flush  = flush_all;
  assign bus.new_pc     = exc_en ? exp_vector : (exrt_en ? epc : 30'd0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (flush_all) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_) state_q <= ST_RUN;
    else         state_q <= state_d;
  end

  pipeline_ctrl_creg_file #(.IRQ_W(IRQ_W), .CREG_N(CREG_N)) u_creg (
    .clk        (clk),
    .reset_     (reset_),
    .exc_en     (exc_en),
    .exc_cause  ({bus.mem_br_flag, exc_code}),
    .exc_epc    (exc_epc),
    .exrt_en    (exrt_en),
    .wr_en      (wr_en),
    .byp_en     (bus.mem_ctrl_op == CTRL_WRCR),
    .wr_addr    (bus.mem_dst_addr),
    .wr_data    (bus.mem_out),
    .irq        (bus.irq),
    .rd_addr    (bus.creg_rd_addr),
    .rd_data    (bus.creg_rd_data),
    .status     (status),
    .epc        (epc),
    .exp_vector (exp_vector),
    .int_mask   (int_mask)
  );
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized bench for pipeline_ctrl against a register-array reference model.
module tb_pipeline_ctrl;
  logic clk = 1'b0;
  logic reset_ = 1'b0;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.IRQ_W(8)) bus();
  pipeline_ctrl #(.IRQ_W(8), .CREG_N(8)) dut (.clk(clk), .reset_(reset_), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  // Model: creg[a] holds the value a read of address a returns.
  logic [31:0] creg [0:5];
  logic [31:0] creg_n [0:5];
  bit in_flush, in_flush_n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fmt(input int a, input logic [31:0] d);
    case (a)
      0, 1:    return d & 32'h3;
      2, 3:    return d & ~32'h3;
      4:       return d & 32'hF;
      5:       return d & 32'hFF;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) creg[i] = 32'h0;
    creg[5] = 32'hFF;
    in_flush = 1'b0;
  endtask

  task automatic idle();
    bus.if_busy = 0; bus.mem_busy = 0; bus.ld_hazard = 0;
    bus.id_pc = '0; bus.mem_pc = '0; bus.mem_en = 0; bus.mem_br_flag = 0;
    bus.mem_ctrl_op = 2'd0; bus.mem_dst_addr = '0; bus.mem_exp_code = 3'd0;
    bus.mem_out = '0; bus.irq = '0; bus.creg_rd_addr = '0;
  endtask

  // Settle, compare every output with the model, and prepare the next model state.
  task automatic eval();
    logic stall, go, intr, exc, exrt, wr, inc;
    logic [2:0] code;
    logic [31:0] e_rd;
    logic [29:0] e_pc, epcw;
    int a, d;
    #2;
    stall = bus.if_busy | bus.mem_busy;
    intr  = creg[0][1] && ((bus.irq & ~creg[5][7:0]) != 8'h0);
    go    = bus.mem_en && !stall;
    exc   = go && ((intr && !in_flush) || bus.mem_exp_code != 3'd0);
    code  = (intr && !in_flush) ? 3'd1 : bus.mem_exp_code;
    exrt  = go && !exc && bus.mem_ctrl_op == 2'd2;
    wr    = go && !exc && !exrt && bus.mem_ctrl_op == 2'd1;
    a = int'(bus.creg_rd_addr);
    d = int'(bus.mem_dst_addr);
    if (a >= 8) e_rd = 32'h0;
    else if (bus.mem_ctrl_op == 2'd1 && d == a && a < 6) e_rd = fmt(a, bus.mem_out);
    else if (a == 6) e_rd = {24'h0, bus.irq};
    else if (a == 7) e_rd = 32'h0;
    else e_rd = creg[a];
    e_pc = exc ? creg[3][31:2] : (exrt ? creg[2][31:2] : 30'h0);
    chk("rd_data", bus.creg_rd_data, e_rd);
    chk("exe_mode", 32'(bus.exe_mode), 32'(creg[0][0]));
    chk("int_detect", 32'(bus.int_detect), 32'(intr));
    chk("stalls", 32'({bus.if_stall, bus.id_stall, bus.ex_stall, bus.mem_stall}),
        32'({stall | bus.ld_hazard, stall, stall, stall}));
    chk("flushes", 32'({bus.if_flush, bus.id_flush, bus.ex_flush, bus.mem_flush}),
        (exc || exrt) ? 32'hF : (bus.ld_hazard ? 32'h4 : 32'h0));
    chk("new_pc", 32'(bus.new_pc), 32'(e_pc));
    creg_n = creg;
    in_flush_n = !in_flush && (exc || exrt);
    if (!reset_) begin
      for (int i = 0; i < 6; i++) creg_n[i] = 32'h0;
      creg_n[5] = 32'hFF;
      in_flush_n = 1'b0;
    end else if (exc) begin
      inc  = (code == 3'd5) && !bus.mem_br_flag;
      epcw = bus.mem_pc + 30'(inc);
      creg_n[1] = creg[0];
      creg_n[0] = 32'h0;
      creg_n[4] = {28'h0, bus.mem_br_flag, code};
      creg_n[2] = {epcw, 2'b00};
    end else if (exrt) begin
      creg_n[0] = creg[1];
    end else if (wr && d < 6) begin
      creg_n[d] = fmt(d, bus.mem_out);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    creg = creg_n;
    in_flush = in_flush_n;
  endtask

  task automatic wrcr(input logic [4:0] a, input logic [31:0] v);
    idle(); bus.mem_en = 1; bus.mem_ctrl_op = 2'd1; bus.mem_dst_addr = a; bus.mem_out = v;
    eval(); tick();
  endtask

  initial begin
    idle();
    reset_ = 0;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    eval(); chk("rst_status", bus.creg_rd_data, 32'h0); chk("rst_mode", 32'(bus.exe_mode), 32'h0);
    tick();
    reset_ = 1;
    idle(); bus.creg_rd_addr = 5; eval(); chk("rst_mask", bus.creg_rd_data, 32'hFF); tick();

    // Vector write, then an undefined-instruction exception.
    wrcr(5'd3, 32'h0000_0100);
    idle(); bus.mem_en = 1; bus.mem_exp_code = 3'd2; bus.mem_pc = 30'h40;
    eval();
    chk("undef_flush", 32'({bus.if_flush, bus.id_flush, bus.ex_flush, bus.mem_flush}), 32'hF);
    chk("undef_new_pc", 32'(bus.new_pc), 32'h40);
    tick();
    idle(); bus.creg_rd_addr = 2; eval(); chk("undef_epc", bus.creg_rd_data, 32'h100); tick();
    idle(); bus.creg_rd_addr = 4; eval(); chk("undef_cause", bus.creg_rd_data, 32'h2); tick();
    idle(); eval(); chk("undef_status", bus.creg_rd_data, 32'h0); tick();

    // TRAP then EXRT resumes after the trap with STATUS restored.
    wrcr(5'd0, 32'h1);
    idle(); bus.mem_en = 1; bus.mem_exp_code = 3'd5; bus.mem_pc = 30'h20; eval(); tick();
    idle(); bus.mem_en = 1; bus.mem_ctrl_op = 2'd2; eval();
    chk("exrt_new_pc", 32'(bus.new_pc), 32'h21); tick();
    idle(); eval(); chk("exrt_mode", 32'(bus.exe_mode), 32'h1); tick();

    // Masked vs unmasked interrupt.
    wrcr(5'd5, 32'hFE);
    wrcr(5'd0, 32'h2);
    idle(); bus.mem_en = 1; bus.irq = 8'h02; eval(); chk("irq_masked", 32'(bus.int_detect), 32'h0); tick();
    idle(); bus.mem_en = 1; bus.irq = 8'h01; eval(); chk("irq_taken", 32'(bus.int_detect), 32'h1);
    chk("irq_new_pc", 32'(bus.new_pc), 32'h40); tick();
    idle(); bus.creg_rd_addr = 4; eval(); chk("irq_cause", bus.creg_rd_data, 32'h1); tick();

    // Load-use bubble.
    idle(); bus.ld_hazard = 1; eval();
    chk("ld_flush", 32'({bus.if_flush, bus.id_flush, bus.ex_flush, bus.mem_flush}), 32'h4);
    chk("ld_stall", 32'({bus.if_stall, bus.id_stall, bus.ex_stall, bus.mem_stall}), 32'h8);
    tick();

    // Overflow held off by mem_busy, taken once it drops.
    idle(); bus.mem_en = 1; bus.mem_busy = 1; bus.mem_exp_code = 3'd3; bus.creg_rd_addr = 4; eval();
    chk("busy_flush", 32'(bus.if_flush), 32'h0); tick();
    idle(); bus.mem_en = 1; bus.mem_busy = 1; bus.mem_exp_code = 3'd3; bus.creg_rd_addr = 4; eval();
    chk("busy_cause", bus.creg_rd_data, 32'h1); tick();
    idle(); bus.mem_en = 1; bus.mem_exp_code = 3'd3; eval();
    chk("unbusy_flush", 32'(bus.mem_flush), 32'h1); tick();
    idle(); bus.creg_rd_addr = 4; eval(); chk("unbusy_cause", bus.creg_rd_data, 32'h3); tick();

    // EPC+1 wraps.
    idle(); bus.mem_en = 1; bus.mem_exp_code = 3'd5; bus.mem_pc = 30'h3FFF_FFFF; eval(); tick();
    idle(); bus.creg_rd_addr = 2; eval(); chk("epc_wrap", bus.creg_rd_data, 32'h0); tick();

    for (int n = 0; n < 4000; n++) begin
      reset_ = ($urandom_range(0, 99) != 0);
      bus.if_busy      = ($urandom_range(0, 7) == 0);
      bus.mem_busy     = ($urandom_range(0, 7) == 0);
      bus.ld_hazard    = ($urandom_range(0, 5) == 0);
      bus.mem_en       = ($urandom_range(0, 3) != 0);
      bus.mem_br_flag  = 1'($urandom);
      bus.mem_ctrl_op  = 2'($urandom);
      bus.mem_dst_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      bus.mem_exp_code = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 6)) : 3'd0;
      bus.mem_out      = $urandom;
      bus.irq          = ($urandom_range(0, 1) == 0) ? 8'h0 : 8'($urandom);
      bus.creg_rd_addr = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      bus.mem_pc       = ($urandom_range(0, 15) == 0) ? 30'h3FFF_FFFF : 30'($urandom);
      bus.id_pc        = 30'($urandom);
      eval();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
